// File: rtl/blink_pkg.sv
// Shared constants for the LED blink-rate sequencer and its decoder: rate codes,
// decoder state encodings, default half-periods and the interval classifier.
package blink_pkg;

   localparam int unsigned HALF0_DEF = 1250000;
   localparam int unsigned HALF1_DEF = 2500000;
   localparam int unsigned HALF2_DEF = 5000000;

   typedef logic [1:0] rate_code_t;

   localparam rate_code_t RATE_C0      = 2'd0;
   localparam rate_code_t RATE_C1      = 2'd1;
   localparam rate_code_t RATE_C2      = 2'd2;
   localparam rate_code_t RATE_INVALID = 2'd3;

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   // |meas - half| <= half >> tol_shift, written without an unsigned underflow
   function automatic logic in_window(input int unsigned meas, input int unsigned half,
                                      input int unsigned tol_shift);
      int unsigned tol;
      tol = half >> tol_shift;
      return ((meas + tol) >= half) && (meas <= (half + tol));
   endfunction

   // Lowest code wins when windows overlap
   function automatic rate_code_t classify(input int unsigned meas, input int unsigned h0,
                                           input int unsigned h1, input int unsigned h2,
                                           input int unsigned tol_shift);
      if (in_window(meas, h0, tol_shift)) return RATE_C0;
      if (in_window(meas, h1, tol_shift)) return RATE_C1;
      if (in_window(meas, h2, tol_shift)) return RATE_C2;
      return RATE_INVALID;
   endfunction

endpackage

// File: rtl/blink_rate_decoder_if.sv
// Monitored blink line and decoded rate status; slave is the decoder side.
interface blink_rate_decoder_if;
   import blink_pkg::*;

   logic       led_in;
   rate_code_t rate_code;
   logic       rate_valid;
   logic       rate_change;
   logic       idle;

   modport master (output led_in, input rate_code, input rate_valid, input rate_change, input idle);
   modport slave  (input led_in, output rate_code, output rate_valid, output rate_change, output idle);

endinterface

// File: rtl/blink_edge_sync.sv
// Synchronizes the asynchronous blink line and emits a one-cycle registered edge pulse.
// With BLINK_DEC_GLITCH_FILTER_EN a level must hold GLITCH_CYCLES cycles before it counts.
module blink_edge_sync
`ifdef BLINK_DEC_GLITCH_FILTER_EN
#(
   parameter int unsigned GLITCH_CYCLES = 16
)
`endif
(
   input  logic clk,
   input  logic rst_n,
   input  logic led_in,
   output logic edge_pulse
);

   logic sync1_q;
   logic sync2_q;
   logic level_c;
   logic level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= led_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef BLINK_DEC_GLITCH_FILTER_EN
   localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);

   logic [GW-1:0] stable_cnt_q;
   logic          filt_q;

   // Accept a new level only after GLITCH_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_cnt_q <= '0;
         filt_q       <= 1'b0;
      end else if (sync2_q == filt_q) begin
         stable_cnt_q <= '0;
      end else if (stable_cnt_q == GW'(GLITCH_CYCLES - 1)) begin
         stable_cnt_q <= '0;
         filt_q       <= sync2_q;
      end else begin
         stable_cnt_q <= GW'(stable_cnt_q + GW'(1));
      end
   end

   assign level_c = filt_q;
`else
   assign level_c = sync2_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q    <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         level_q    <= level_c;
         edge_pulse <= level_c ^ level_q;
      end
   end

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures the toggle interval of a blink line, classifies it into a rate code and
// reports a locked rate once LOCK_COUNT consecutive intervals agree. Optional input
// glitch filter: BLINK_DEC_GLITCH_FILTER_EN.
module blink_rate_decoder
   import blink_pkg::*;
#(
   parameter int unsigned HALF0         = HALF0_DEF,
   parameter int unsigned HALF1         = HALF1_DEF,
   parameter int unsigned HALF2         = HALF2_DEF,
   parameter int unsigned TOL_SHIFT     = 4,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned TIMEOUT       = 10000000,
   parameter int unsigned CNT_W         = 26,
   parameter int unsigned GLITCH_CYCLES = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   blink_rate_decoder_if.slave blink
);

   localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

   logic             edge_pulse;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       state_q, state_d;
   rate_code_t       cand_q, cand_d;
   rate_code_t       code_q, code_d;
   logic [MW-1:0]    match_q, match_d;
   logic             change_d;
   logic             valid_q, change_q, idle_q;
   rate_code_t       cls_c;
   logic             timeout_c;

`ifdef BLINK_DEC_GLITCH_FILTER_EN
   blink_edge_sync #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_edge_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .led_in    (blink.led_in),
      .edge_pulse(edge_pulse)
   );
`else
   blink_edge_sync u_edge_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .led_in    (blink.led_in),
      .edge_pulse(edge_pulse)
   );

   if (GLITCH_CYCLES == 0) begin : g_bad_glitch_cfg
      $error("GLITCH_CYCLES must be nonzero");
   end
`endif

   // The interval just ended is the counter value at the edge
   assign cls_c     = classify(32'(cnt_q), HALF0, HALF1, HALF2, TOL_SHIFT);
   assign timeout_c = !edge_pulse && (cnt_q == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (edge_pulse) begin
         cnt_q <= CNT_W'(1);
      end else if (cnt_q != CNT_W'(TIMEOUT)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEARCH;
         cand_q  <= RATE_INVALID;
         match_q <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         match_q <= match_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      match_d  = match_q;
      code_d   = code_q;
      change_d = 1'b0;
      if (edge_pulse) begin
         case (state_q)
            SEARCH: begin
               state_d = MEASURE;
            end
            MEASURE: begin
               if (cls_c == RATE_INVALID) begin
                  cand_d  = RATE_INVALID;
                  match_d = '0;
               end else if (cls_c == cand_q) begin
                  match_d = MW'(match_q + MW'(1));
               end else begin
                  cand_d  = cls_c;
                  match_d = MW'(1);
               end
               if ((cls_c != RATE_INVALID) && (match_d >= MW'(LOCK_COUNT))) begin
                  state_d  = LOCKED;
                  code_d   = cand_d;
                  change_d = 1'b1;
               end
            end
            LOCKED: begin
               if (cls_c == RATE_INVALID) begin
                  state_d = MEASURE;
                  cand_d  = RATE_INVALID;
                  match_d = '0;
               end else if (cls_c != cand_q) begin
                  state_d = MEASURE;
                  cand_d  = cls_c;
                  match_d = MW'(1);
               end
            end
            default: begin
               state_d = SEARCH;
               match_d = '0;
            end
         endcase
      end else if (timeout_c) begin
         state_d = SEARCH;
         match_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q   <= RATE_C0;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         code_q   <= code_d;
         valid_q  <= (state_d == LOCKED);
         change_q <= change_d;
         idle_q   <= (state_d == SEARCH);
      end
   end

   assign blink.rate_code   = code_q;
   assign blink.rate_valid  = valid_q;
   assign blink.rate_change = change_q;
   assign blink.idle        = idle_q;

endmodule
